// File: rtl/mem_slot_arbiter_pkg.sv
// mem_slot_pkg: owner encoding and slot phase constants shared by the slot arbiter files
package mem_slot_pkg;
  typedef enum logic [2:0] {OWN_NONE, OWN_VIDEO, OWN_SOUND, OWN_DSK_INT, OWN_DSK_EXT, OWN_CPU} owner_t;
  localparam logic [1:0] PH_ARB = 2'd3;
  localparam logic [1:0] PH_LATCH = 2'd2;
  localparam int CPU_WAIT_W = 3;
endpackage

// File: rtl/mem_slot_arbiter_if.sv
// mem_slot_arbiter_if: clk8 enable and requests in (master drives), slot phase, ownership, strobes and acks out (slave drives)
interface mem_slot_arbiter_if;
  logic clk8_en_p;
  logic cpuReq, videoReq, soundReq, dskReqInt, dskReqExt;
  logic [1:0] slotPhase;
  logic cpuBusControl, videoBusControl, soundBusControl, dskBusInt, dskBusExt, busIdle;
  logic memoryLatch, loadPixels, loadSound;
  logic dskReadAckInt, dskReadAckExt, cpuAck;
  modport master (
    output clk8_en_p, cpuReq, videoReq, soundReq, dskReqInt, dskReqExt,
    input slotPhase, cpuBusControl, videoBusControl, soundBusControl, dskBusInt, dskBusExt, busIdle,
    input memoryLatch, loadPixels, loadSound, dskReadAckInt, dskReadAckExt, cpuAck
  );
  modport slave (
    input clk8_en_p, cpuReq, videoReq, soundReq, dskReqInt, dskReqExt,
    output slotPhase, cpuBusControl, videoBusControl, soundBusControl, dskBusInt, dskBusExt, busIdle,
    output memoryLatch, loadPixels, loadSound, dskReadAckInt, dskReadAckExt, cpuAck
  );
endinterface

// File: rtl/mem_slot_arbiter_prio.sv
// mem_slot_prio: fixed-priority slot owner pick from the five requests plus the CPU starvation flag
module mem_slot_prio
  import mem_slot_pkg::*;
(
  input  logic   videoReq,
  input  logic   cpuReq,
  input  logic   soundReq,
  input  logic   dskReqInt,
  input  logic   dskReqExt,
  input  logic   cpuStarved,
  output owner_t owner
);
  assign owner = videoReq              ? OWN_VIDEO   :
                 (cpuReq && cpuStarved) ? OWN_CPU     :
                 soundReq              ? OWN_SOUND   :
                 dskReqInt             ? OWN_DSK_INT :
                 dskReqExt             ? OWN_DSK_EXT :
                 cpuReq                ? OWN_CPU     : OWN_NONE;
endmodule

// File: rtl/mem_slot_arbiter.sv
// mem_slot_arbiter: 4-phase clk8 memory slot arbiter; clk32, async active-low _systemReset, bus (slave) carries requests, ownership, strobes and acks
module mem_slot_arbiter
  import mem_slot_pkg::*;
#(
  parameter int CPU_MAX_WAIT = 2,
  parameter int SLOT_PHASES  = 4
) (
  input logic clk32,
  input logic _systemReset,
  mem_slot_arbiter_if.slave bus
);
  if (SLOT_PHASES != 4 || CPU_MAX_WAIT < 1 || CPU_MAX_WAIT > 7) begin : g_bad_param
    $error("mem_slot_arbiter: unsupported SLOT_PHASES or CPU_MAX_WAIT");
  end
  owner_t owner, pick;
  logic [1:0] phase;
  logic [CPU_WAIT_W-1:0] cpu_wait;
  logic arb_tick, ack_int, ack_ext, ack_cpu;
  assign arb_tick = bus.clk8_en_p && phase == PH_ARB;
  mem_slot_prio u_prio (
    .videoReq  (bus.videoReq),
    .cpuReq    (bus.cpuReq),
    .soundReq  (bus.soundReq),
    .dskReqInt (bus.dskReqInt),
    .dskReqExt (bus.dskReqExt),
    .cpuStarved(cpu_wait >= CPU_WAIT_W'(CPU_MAX_WAIT)),
    .owner     (pick)
  );
  always_ff @(posedge clk32 or negedge _systemReset)
    if (!_systemReset) begin
      phase    <= '0;
      owner    <= OWN_NONE;
      cpu_wait <= '0;
      ack_int  <= 1'b0;
      ack_ext  <= 1'b0;
      ack_cpu  <= 1'b0;
    end else begin
      if (bus.clk8_en_p) phase <= phase + 2'd1;
      if (arb_tick) begin
        owner    <= pick;
        cpu_wait <= (bus.cpuReq && pick != OWN_CPU) ? (cpu_wait == '1 ? cpu_wait : cpu_wait + CPU_WAIT_W'(1)) : '0;
      end
      ack_int <= bus.memoryLatch && owner == OWN_DSK_INT;
      ack_ext <= bus.memoryLatch && owner == OWN_DSK_EXT;
      ack_cpu <= bus.memoryLatch && owner == OWN_CPU;
    end
  assign bus.slotPhase       = phase;
  assign bus.cpuBusControl   = owner == OWN_CPU;
  assign bus.videoBusControl = owner == OWN_VIDEO;
  assign bus.soundBusControl = owner == OWN_SOUND;
  assign bus.dskBusInt       = owner == OWN_DSK_INT;
  assign bus.dskBusExt       = owner == OWN_DSK_EXT;
  assign bus.busIdle         = owner == OWN_NONE;
  assign bus.memoryLatch     = bus.clk8_en_p && phase == PH_LATCH && owner != OWN_NONE;
  assign bus.loadPixels      = bus.memoryLatch && bus.videoBusControl;
  assign bus.loadSound       = bus.memoryLatch && bus.soundBusControl;
  assign bus.dskReadAckInt   = ack_int;
  assign bus.dskReadAckExt   = ack_ext;
  assign bus.cpuAck          = ack_cpu;
  a_owner_onehot: assert property (@(posedge clk32) disable iff (!_systemReset)
    $onehot0({bus.cpuBusControl, bus.videoBusControl, bus.soundBusControl, bus.dskBusInt, bus.dskBusExt}));
endmodule

// File: tb/tb_mem_slot_arbiter.sv
// tb_mem_slot_arbiter: table-driven priority check plus directed slot sequences for mem_slot_arbiter
module tb_mem_slot_arbiter;
  import mem_slot_pkg::*;
  localparam logic [5:0] O_CPU = 6'b100000, O_VID = 6'b010000, O_SND = 6'b001000;
  localparam logic [5:0] O_INT = 6'b000100, O_EXT = 6'b000010, O_IDLE = 6'b000001;
  logic clk32 = 1'b0;
  logic _systemReset = 1'b0;
  mem_slot_arbiter_if bus();
  mem_slot_arbiter #(.CPU_MAX_WAIT(2), .SLOT_PHASES(4)) dut (
    .clk32(clk32),
    ._systemReset(_systemReset),
    .bus(bus)
  );
  logic p_video, p_cpu, p_sound, p_int, p_ext, p_starved;
  owner_t p_owner;
  mem_slot_prio u_prio (
    .videoReq(p_video), .cpuReq(p_cpu), .soundReq(p_sound),
    .dskReqInt(p_int), .dskReqExt(p_ext), .cpuStarved(p_starved), .owner(p_owner)
  );
  always #5 clk32 = ~clk32;
  int n_chk = 0, n_fail = 0;
  int c_latch = 0, c_pix = 0, c_snd = 0, c_cpu = 0, c_int = 0, c_ext = 0;
  always @(negedge clk32) begin
    if (bus.memoryLatch) c_latch++;
    if (bus.loadPixels) c_pix++;
    if (bus.loadSound) c_snd++;
    if (bus.cpuAck) c_cpu++;
    if (bus.dskReadAckInt) c_int++;
    if (bus.dskReadAckExt) c_ext++;
  end
  typedef struct {
    logic [5:0] req;
    owner_t     exp;
  } pvec_t;
  pvec_t pv [13];
  logic [5:0] seq3 [6];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    end
  endtask
  function automatic logic [5:0] own();
    return {bus.cpuBusControl, bus.videoBusControl, bus.soundBusControl, bus.dskBusInt, bus.dskBusExt, bus.busIdle};
  endfunction
  task automatic tick();
    @(posedge clk32);
    #1 bus.clk8_en_p = 1'b1;
    @(posedge clk32);
    #1 bus.clk8_en_p = 1'b0;
  endtask
  task automatic do_reset();
    {bus.clk8_en_p, bus.cpuReq, bus.videoReq, bus.soundReq, bus.dskReqInt, bus.dskReqExt} = '0;
    _systemReset = 1'b0;
    repeat (2) @(posedge clk32);
    #1 _systemReset = 1'b1;
  endtask
  task automatic align();
    repeat (3) tick();
  endtask
  task automatic run_slot(output logic [5:0] o, output logic held);
    tick();
    o = own();
    held = 1'b1;
    repeat (3) begin
      tick();
      if (own() !== o) held = 1'b0;
    end
    @(negedge clk32);
    #1;
  endtask
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [5:0] o;
    logic held;
    int s_latch, s_pix, s_snd, s_cpu, s_int, s_ext;
    pv[0]  = '{6'b000000, OWN_NONE};
    pv[1]  = '{6'b100000, OWN_VIDEO};
    pv[2]  = '{6'b111111, OWN_VIDEO};
    pv[3]  = '{6'b010000, OWN_CPU};
    pv[4]  = '{6'b011000, OWN_SOUND};
    pv[5]  = '{6'b011001, OWN_CPU};
    pv[6]  = '{6'b001001, OWN_SOUND};
    pv[7]  = '{6'b001110, OWN_SOUND};
    pv[8]  = '{6'b000110, OWN_DSK_INT};
    pv[9]  = '{6'b000010, OWN_DSK_EXT};
    pv[10] = '{6'b010010, OWN_DSK_EXT};
    pv[11] = '{6'b010101, OWN_CPU};
    pv[12] = '{6'b000001, OWN_NONE};
    seq3 = '{O_SND, O_SND, O_CPU, O_SND, O_SND, O_CPU};
    for (int i = 0; i < 13; i++) begin
      {p_video, p_cpu, p_sound, p_int, p_ext, p_starved} = pv[i].req;
      #1 chk($sformatf("prio[%0d]", i), 32'(p_owner), 32'(pv[i].exp));
    end
    do_reset();
    #1;
    chk("reset_phase", 32'(bus.slotPhase), 0);
    chk("reset_owner", 32'(own()), 32'(O_IDLE));
    chk("reset_strobes", 32'({bus.memoryLatch, bus.loadPixels, bus.loadSound, bus.cpuAck, bus.dskReadAckInt, bus.dskReadAckExt}), 0);
    bus.cpuReq = 1'b1;
    align();
    @(negedge clk32);
    #1;
    chk("cpu_pre_arb_idle", 32'(own()), 32'(O_IDLE));
    chk("cpu_pre_arb_latch", 32'(c_latch), 0);
    for (int s = 0; s < 3; s++) begin
      s_latch = c_latch; s_cpu = c_cpu;
      run_slot(o, held);
      chk($sformatf("cpu_slot%0d_owner", s), 32'(o), 32'(O_CPU));
      chk($sformatf("cpu_slot%0d_held", s), 32'(held), 1);
      chk($sformatf("cpu_slot%0d_latch", s), 32'(c_latch - s_latch), 1);
      chk($sformatf("cpu_slot%0d_ack", s), 32'(c_cpu - s_cpu), 1);
    end
    repeat (3) tick();
    chk("cpu_phase2", 32'(bus.slotPhase), 2);
    @(posedge clk32);
    #1 bus.clk8_en_p = 1'b1;
    #1 chk("latch_at_phase2", 32'({bus.memoryLatch, bus.cpuAck}), 32'(2'b10));
    @(posedge clk32);
    #1 bus.clk8_en_p = 1'b0;
    #1 chk("ack_after_latch", 32'({bus.memoryLatch, bus.cpuAck}), 32'(2'b01));
    @(posedge clk32);
    #1 chk("ack_one_cycle", 32'(bus.cpuAck), 0);
    do_reset();
    {bus.videoReq, bus.cpuReq, bus.soundReq, bus.dskReqInt} = 4'b1111;
    align();
    s_cpu = c_cpu; s_int = c_int; s_ext = c_ext; s_snd = c_snd;
    for (int s = 0; s < 9; s++) begin
      s_pix = c_pix;
      run_slot(o, held);
      chk($sformatf("video_slot%0d_owner", s), 32'(o), 32'(O_VID));
      chk($sformatf("video_slot%0d_pix", s), 32'(c_pix - s_pix), 1);
    end
    chk("video_no_acks", 32'((c_cpu - s_cpu) + (c_int - s_int) + (c_ext - s_ext) + (c_snd - s_snd)), 0);
    bus.videoReq = 1'b0;
    run_slot(o, held);
    chk("video_drop_cpu_starved", 32'(o), 32'(O_CPU));
    do_reset();
    {bus.soundReq, bus.dskReqInt, bus.cpuReq} = 3'b111;
    align();
    for (int s = 0; s < 6; s++) begin
      s_snd = c_snd;
      run_slot(o, held);
      chk($sformatf("starve_slot%0d", s), 32'(o), 32'(seq3[s]));
      if (seq3[s] == O_SND) chk($sformatf("starve_slot%0d_loadsnd", s), 32'(c_snd - s_snd), 1);
    end
    do_reset();
    {bus.dskReqInt, bus.dskReqExt} = 2'b11;
    align();
    s_int = c_int; s_ext = c_ext;
    run_slot(o, held);
    chk("dsk_slot0_owner", 32'(o), 32'(O_INT));
    chk("dsk_slot0_acks", 32'({8'(c_int - s_int), 8'(c_ext - s_ext)}), 32'(16'h0100));
    bus.dskReqInt = 1'b0;
    run_slot(o, held);
    chk("dsk_slot1_owner", 32'(o), 32'(O_EXT));
    chk("dsk_slot1_acks", 32'({8'(c_int - s_int), 8'(c_ext - s_ext)}), 32'(16'h0101));
    bus.dskReqExt = 1'b0;
    s_latch = c_latch;
    run_slot(o, held);
    chk("dsk_slot2_idle", 32'(o), 32'(O_IDLE));
    chk("dsk_slot2_latch", 32'(c_latch - s_latch), 0);
    do_reset();
    align();
    s_ext = c_ext;
    bus.dskReqExt = 1'b1;
    tick();
    bus.dskReqExt = 1'b0;
    for (int p = 0; p < 4; p++) begin
      if (p > 0) tick();
      chk($sformatf("pulse_ph%0d", p), 32'({bus.slotPhase, own()}), 32'({2'(p), O_EXT}));
    end
    @(negedge clk32);
    #1 chk("pulse_ack", 32'(c_ext - s_ext), 1);
    tick();
    chk("pulse_next_idle", 32'(own()), 32'(O_IDLE));
    do_reset();
    bus.cpuReq = 1'b1;
    align();
    tick();
    chk("rst_slot_owner", 32'(own()), 32'(O_CPU));
    repeat (2) tick();
    s_cpu = c_cpu; s_latch = c_latch;
    #2 _systemReset = 1'b0;
    #1 chk("rst_async_clear", 32'({bus.slotPhase, own()}), 32'({2'd0, O_IDLE}));
    repeat (2) @(posedge clk32);
    #1 _systemReset = 1'b1;
    held = 1'b1;
    repeat (3) begin
      tick();
      if (own() !== O_IDLE) held = 1'b0;
    end
    chk("rst_idle_3_ticks", 32'(held), 1);
    tick();
    chk("rst_grant_4th_tick", 32'({bus.slotPhase, own()}), 32'({2'd0, O_CPU}));
    chk("rst_no_ack", 32'({8'(c_cpu - s_cpu), 8'(c_latch - s_latch)}), 0);
    repeat (3) tick();
    @(negedge clk32);
    #1 chk("rst_next_ack", 32'(c_cpu - s_cpu), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_slot_arbiter.md
Name: mem_slot_arbiter

Overview:
- Time-slot arbiter for the shared RAM/ROM data bus used by the CPU, the video fetch, the sound fetch and the two floppy disk-read channels (internal and external).
- Divides clk8 into 4-phase memory slots and grants each slot to exactly one requester, or to none.
- Drives the bus-control, latch and load strobes consumed by the data controller, video shifter and IWM.
- Sits between the address/timing generator, which raises the requests, and the data controller.

Parameters:
- CPU_MAX_WAIT, 2: number of consecutive slots the CPU may be denied before it preempts sound and disk requests (range 1..7).
- SLOT_PHASES, 4: clk8_en_p ticks per slot. Fixed at 4; other values are unsupported.

Ports:
- clk32  in  1  32.5 MHz system clock
- _systemReset  in  1  asynchronous, active-low reset
- clk8_en_p  in  1  clk8 rising-edge enable, one clk32 wide
- cpuReq  in  1  CPU access pending (level)
- videoReq  in  1  video word fetch pending (level)
- soundReq  in  1  sound/PWM word fetch pending (level)
- dskReqInt  in  1  internal-drive read pending (level)
- dskReqExt  in  1  external-drive read pending (level)
- slotPhase  out  2  current phase within the slot, 0..3
- cpuBusControl  out  1  slot owned by the CPU
- videoBusControl  out  1  slot owned by video
- soundBusControl  out  1  slot owned by sound
- dskBusInt  out  1  slot owned by the internal disk
- dskBusExt  out  1  slot owned by the external disk
- memoryLatch  out  1  data-valid strobe, one clk32 wide
- loadPixels  out  1  memoryLatch qualified by videoBusControl
- loadSound  out  1  memoryLatch qualified by soundBusControl
- dskReadAckInt  out  1  one-clk32 acknowledge to the internal disk
- dskReadAckExt  out  1  one-clk32 acknowledge to the external disk
- cpuAck  out  1  one-clk32 acknowledge to the CPU
- busIdle  out  1  no owner for the current slot

Behaviour:
- Reset is asynchronous and active-low on _systemReset; the block is clocked on clk32.
- Reset values:
  - slotPhase = 0.
  - All *BusControl, dskBus*, ack and strobe outputs = 0.
  - busIdle = 1.
  - cpuWait counter = 0.
- Phase counter:
  - Advances only on clk8_en_p.
  - Sequence is 0→1→2→3→0, with free-running wrap.
  - The counter stays stalled while clk8_en_p is low.
- Arbitration:
  - Evaluated on the clk8_en_p tick where slotPhase == 3.
  - The new owner is registered together with the transition to phase 0.
  - The owner is held constant for phases 0..3 of the slot.
- Priority, highest first:
  1. videoReq. Absolute; never preempted.
  2. cpuReq, but only if cpuWait >= CPU_MAX_WAIT (starvation override).
  3. soundReq.
  4. dskReqInt.
  5. dskReqExt.
  6. cpuReq.
  7. None: all ownership outputs 0 and busIdle = 1.
- Exactly one ownership output is 1 at any time, or none of them. This is one-hot or zero, checked by assertion.
- Requests are sampled only at arbitration. A request dropping mid-slot does not abort the slot: the access and its ack still occur.
- memoryLatch:
  - Combinational: clk8_en_p AND slotPhase == 2 AND not busIdle.
  - This gives exactly one clk32 pulse per owned slot.
- loadPixels and loadSound are combinational qualifications of memoryLatch.
- Acks:
  - Registered, asserted on the clk32 cycle immediately after memoryLatch, for the slot owner only.
  - Video and sound receive no ack; their load strobe serves as the acknowledge.
- Requesters must deassert their request by the arbitration tick following their ack; otherwise they are granted again. Back-to-back grants to the same requester are legal.
- cpuWait counter:
  - At each arbitration, if cpuReq = 1 and CPU not granted: cpuWait + 1, saturating at 7.
  - If the CPU is granted, or cpuReq = 0: cpuWait = 0.
- Simultaneous requests: resolved purely by the priority list above. Both disk requests together are served Int first, then Ext in the next slot.
- Reset mid-slot:
  - All outputs are cleared immediately and no pending ack is emitted.
  - After release, the first arbitration occurs at the first phase-3 tick.
- clk8_en_p asserted on consecutive clk32 cycles is legal; phases advance every tick.

Decomposition:
- Package mem_slot_pkg:
  - typedef owner_t enum {OWN_NONE, OWN_VIDEO, OWN_SOUND, OWN_DSK_INT, OWN_DSK_EXT, OWN_CPU}.
  - Constants PH_ARB = 2'd3 and PH_LATCH = 2'd2.
  - CPU_WAIT_W = 3.
- One natural sub-module, mem_slot_prio: combinational priority pick.
  - Inputs: the requests and cpuStarved.
  - Output: owner_t.
  - Lets the bench check it exhaustively in isolation.
- The top level holds the phase counter, the owner register, cpuWait and ack registers.

Test Plan:
- Reset release with only cpuReq = 1:
  - First grant goes to the CPU at the next phase-0.
  - memoryLatch pulses once at phase 2.
  - cpuAck pulses on the following clk32.
  - Repeats every 4 clk8 ticks while cpuReq stays 1.
- videoReq, cpuReq, soundReq and dskReqInt all held at 1:
  - Every slot is videoBusControl.
  - loadPixels fires once per slot.
  - No other grant and no acks occur.
  - cpuWait saturates at 7.
- CPU_MAX_WAIT = 2, with soundReq, dskReqInt and cpuReq held at 1 and video at 0:
  - Slot grants follow sound, sound, CPU, sound, sound, CPU.
- dskReqInt and dskReqExt raised together, each dropped on its own ack:
  - Grants are dskBusInt, then dskBusExt.
  - Exactly one dskReadAckInt and then one dskReadAckExt.
  - busIdle = 1 in the third slot.
- dskReqExt pulsed high only around the arbitration tick, then dropped in phase 0:
  - The slot completes with dskBusExt = 1 for 4 phases and one dskReadAckExt.
- _systemReset asserted at phase 2 of a CPU slot, before memoryLatch:
  - Outputs clear asynchronously.
  - No cpuAck is issued.
  - slotPhase = 0 after release.
  - The next grant occurs after 4 clk8_en_p ticks.
